// File: rtl/mem_pkg.sv
// Shared memory-side constants: bus widths and requester IDs used by the
// read arbiter, the fetch unit and the LD unit.
package mem_pkg;
  localparam int AW = 16;
  localparam int DW = 16;

  localparam int REQ_IF = 0;
  localparam int REQ_LD = 1;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory reads; the head is
// visible combinationally so a returning beat can be routed in the same cycle.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [IW-1:0] i_din,
  output logic [IW-1:0] o_head,
  output logic [CW-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/mem_rd_arb.sv
// Round-robin arbiter sharing one memory read port among N_REQ requesters,
// with registered issue and in-order routing of returned beats.
module mem_rd_arb #(
  parameter int N_REQ = 2,
  parameter int DEPTH = 4,
  parameter int AW    = mem_pkg::AW,
  parameter int DW    = mem_pkg::DW
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req_re,
  input  logic [N_REQ*AW-1:0]          i_req_raddr,
  output logic [N_REQ-1:0]             o_req_grant,
  output logic [N_REQ-1:0]             o_resp_valid,
  output logic [AW-1:0]                o_resp_addr,
  output logic [DW-1:0]                o_resp_data,
  output logic                         o_mem_re,
  output logic [AW-1:0]                o_mem_raddr,
  input  logic [AW-1:0]                i_mem_addr_out,
  input  logic [DW-1:0]                i_mem_data_out,
  input  logic                         i_mem_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_outstanding,
  output logic                         o_err_unexp
);
  localparam int IW = mem_pkg::idx_w(N_REQ);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]    r_rr;
  logic             r_mem_re;
  logic [AW-1:0]    r_mem_raddr;
  logic [N_REQ-1:0] r_resp_valid;
  logic [AW-1:0]    r_resp_addr;
  logic [DW-1:0]    r_resp_data;
  logic             r_err_unexp;

  logic             w_grant_vld;
  logic [IW-1:0]    w_grant_id;
  int               w_idx;
  logic [CW-1:0]    w_count;
  logic [IW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [AW-1:0]    w_addr [N_REQ];
  logic [N_REQ-1:0] w_head_oh;

  assign w_full  = (w_count == CW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_pop   = i_mem_ready && !w_empty;

  // First asserting requester at or after r_rr, wrapping; nothing while full or in reset.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = 0;
    if (i_rst_n && !w_full) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = (int'(r_rr) + k) % N_REQ;
        if (!w_grant_vld && i_req_re[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = IW'(w_idx);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_addr[gi]      = i_req_raddr[gi*AW +: AW];
      assign o_req_grant[gi] = w_grant_vld && (w_grant_id == IW'(gi));
      assign w_head_oh[gi]   = (w_head == IW'(gi));
    end
  endgenerate

  id_fifo #(.DEPTH(DEPTH), .IW(IW), .CW(CW)) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_grant_vld),
    .i_pop   (w_pop),
    .i_din   (w_grant_id),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr         <= IW'(mem_pkg::REQ_IF);
      r_mem_re     <= 1'b0;
      r_mem_raddr  <= '0;
      r_resp_valid <= '0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
      r_err_unexp  <= 1'b0;
    end else begin
      r_mem_re <= w_grant_vld;
      if (w_grant_vld) begin
        r_mem_raddr <= w_addr[w_grant_id];
        r_rr        <= (int'(w_grant_id) == N_REQ - 1) ? '0 : w_grant_id + 1'b1;
      end
      r_resp_valid <= w_pop ? w_head_oh : '0;
      if (w_pop) begin
        r_resp_addr <= i_mem_addr_out;
        r_resp_data <= i_mem_data_out;
      end
      if (i_mem_ready && w_empty) r_err_unexp <= 1'b1;
    end
  end

  assign o_mem_re      = r_mem_re;
  assign o_mem_raddr   = r_mem_raddr;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_addr   = r_resp_addr;
  assign o_resp_data   = r_resp_data;
  assign o_outstanding = w_count;
  assign o_err_unexp   = r_err_unexp;
endmodule

// File: doc/mem_rd_arb.md
# mem_rd_arb

Shares the single memory read port between `N_REQ` read requesters: instruction fetch and the LD unit's miss path today, with room for more. Arbitration is round-robin. Accepted requests are driven onto the memory port through registers. Each returning `mem_ready` beat is routed back to the requester that issued it, using an in-order FIFO of requester IDs. The block sits between the requesters and the memory model, replacing their direct `mem_re`/`mem_raddr` connections.

## Interface
- `N_REQ`, 2, number of requesters; ID 0 = fetch, ID 1 = LD unit.
- `DEPTH`, 4, maximum outstanding memory reads (ID FIFO depth); power of two.
- `AW`, 16, address width.
- `DW`, 16, data width.

- `clk` in 1: sole clock; all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_re` in `N_REQ`: per-requester read request, level.
- `req_raddr` in `N_REQ*AW`: packed addresses; requester i occupies `[i*AW +: AW]`.
- `req_grant` out `N_REQ`: combinational one-hot; request accepted this cycle.
- `resp_valid` out `N_REQ`: registered one-hot; response for requester i.
- `resp_addr` out `AW`: registered address of the response.
- `resp_data` out `DW`: registered data of the response.
- `mem_re` out 1: registered read enable to memory.
- `mem_raddr` out `AW`: registered read address to memory.
- `mem_addr_out` in `AW`: address returned by memory.
- `mem_data_out` in `DW`: data returned by memory.
- `mem_ready` in 1: return beat valid.
- `outstanding` out `clog2(DEPTH+1)`: count of issued, unreturned reads.
- `err_unexp` out 1: sticky; set if `mem_ready` arrives while `outstanding`==0.

## Operation
- **Request hold rule.** A requester holds `req_re` and its address stable until it sees `req_grant[i]`=1 in the same cycle. A request may be dropped only after it is granted.
- **Arbitration.** Each cycle, if `outstanding` < `DEPTH`, grant the first asserting requester at or after round-robin pointer `rr`, searching upward with wrap.
  - At most one grant per cycle.
  - On a grant to i, `rr` becomes (i+1) mod `N_REQ`.
  - With no grant, `rr` holds.
- **Full condition.** Fullness uses the current `outstanding` only. A pop in the same cycle does not enable a grant; there is no bypass.
- **Issue.** On a grant, at the next edge: `mem_re`←1, `mem_raddr`←granted address, and the granted ID is pushed into the FIFO. With no grant: `mem_re`←0 and `mem_raddr` holds its last value.
- **Return.** Memory returns in issue order. When `mem_ready`=1 and the FIFO is non-empty, pop the head ID h. At the next edge: `resp_valid`←one-hot(h), `resp_addr`←`mem_addr_out`, `resp_data`←`mem_data_out`. Otherwise `resp_valid`←0, and addr/data hold.
- **Unexpected beat.** `mem_ready` with an empty FIFO is ignored and sets `err_unexp`. Only reset clears it.
- **Counter.** `outstanding` = push − pop each cycle. A simultaneous push and pop leaves it unchanged.

## Timing
- Grant to `mem_re` high: 1 cycle.
- `mem_ready` to `resp_valid`: 1 cycle.
- Back-to-back grants are allowed every cycle until `outstanding` reaches `DEPTH`.
- **Reset (`rst_n`=0 at posedge).**
  - `mem_re`=0, `mem_raddr`=0, `resp_valid`=0, `resp_addr`=0, `resp_data`=0.
  - `outstanding`=0, `rr`=0, `err_unexp`=0, FIFO pointers=0.
  - `req_grant` is forced to 0 while `rst_n`=0.
- **Reset mid-operation.** In-flight reads are forgotten. Their later `mem_ready` beats set `err_unexp`. Requesters must be reset together with this block.
- **Pointer wrap.** FIFO pointers are `clog2(DEPTH)` bits and wrap naturally. Full/empty is derived from `outstanding`, not from the pointers.

## Structure
- Shared package `mem_pkg`: `AW`, `DW`, requester ID constants `REQ_IF`=0 and `REQ_LD`=1. The LD unit and fetch import the same package.
- One sub-module: `id_fifo`, a synchronous FIFO of `clog2(N_REQ)`-bit IDs.
  - Ports: push, pop, din, head, count; depth `DEPTH`.
  - Synchronous active-low reset.
- Arbiter, issue registers and response registers live in `mem_rd_arb` itself.

## Test plan
- **Single request.** Reset, then `req_re[1]`=1, addr 0x0040, for one cycle → `req_grant`=2'b10 that cycle. Next cycle `mem_re`=1, `mem_raddr`=0x0040, `outstanding`=1. Then `mem_ready` with data 0xBEEF → next cycle `resp_valid`=2'b10, `resp_data`=0xBEEF, `outstanding`=0.
- **Both requesting.** Both requesters hold requests continuously, addrs 0x10 and 0x20 → grants alternate 01,10,01,10. `mem_raddr` sequence is 0x10,0x20,0x10,0x20. Grants stop after 4 while `outstanding`=4.
- **Full with simultaneous pop.** At `outstanding`=4, assert `mem_ready` with a pending request → no grant that cycle. The grant occurs the following cycle. Responses return to IDs in issue order.
- **Unexpected beat.** After reset, `mem_ready`=1 with nothing outstanding → `resp_valid` stays 0 and `err_unexp`=1 from the next cycle until reset.
- **Reset mid-flight.** Pull `rst_n` low for one cycle with 3 reads in flight → `outstanding`=0, `mem_re`=0 and `rr`=0 next cycle. The first grant after reset goes to ID 0 when both request.
